regfile_mp: RTL



---
 rtl/regfile_mp_pkg.sv | 17 +
 rtl/regfile_mp_scoreboard.sv | 48 ++++
 rtl/regfile_mp.sv | 74 +++++++
 3 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants, address type and helpers for the multi-port register file.
package regfile_mp_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;
  localparam int NWR_DEF  = 2;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  // Callers zero-extend their address to 32 bits so any AW can use this.
  function automatic logic zero_addr_f(input logic [31:0] addr);
    return (addr == 32'd0);
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy bits: alloc sets, writeback clears, alloc wins on a tie.
module regfile_mp_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int NWR      = NWR_DEF,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  output logic [NREG-1:0]   busy,
  output logic [NREG-1:0]   busy_vec
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREG; r++) begin
      if (!((ZERO_REG == 1) && (r == 0))) begin
        if (alloc_en && (alloc_addr == AW'(r))) begin
          busy_d[r] = 1'b1;
        end else begin
          for (int j = 0; j < NWR; j++) begin
            if (we[j] && (waddr[j*AW +: AW] == AW'(r))) busy_d[r] = 1'b0;
          end
        end
      end else begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy     = busy_q;
  assign busy_vec = rst ? '0 : busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int NWR      = NWR_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NRD*$clog2(NREG)-1:0] raddr,
  output logic [NRD*XLEN-1:0]         rdata,
  output logic [NRD-1:0]              rbusy,
  input  logic [NWR-1:0]              we,
  input  logic [NWR*$clog2(NREG)-1:0] waddr,
  input  logic [NWR*XLEN-1:0]         wdata,
  input  logic                        alloc_en,
  input  logic [$clog2(NREG)-1:0]     alloc_addr,
  output logic [NREG-1:0]             busy_vec
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;

  function automatic logic is_x0(input logic [AW-1:0] a);
    return (ZERO_REG == 1) && zero_addr_f(32'(a));
  endfunction

  regfile_mp_scoreboard #(
    .NREG(NREG), .NWR(NWR), .ZERO_REG(ZERO_REG), .AW(AW)
  ) u_scoreboard (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy(busy), .busy_vec(busy_vec)
  );

  // Ports are applied in ascending order so the highest-index writer lands last.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && !is_x0(waddr[j*AW +: AW])) mem[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      rdata[i*XLEN +: XLEN] = mem[raddr[i*AW +: AW]];
      rbusy[i]              = busy[raddr[i*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW])) begin
          rdata[i*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
          rbusy[i]              = 1'b0;
        end
      end
`endif
      if (rst || is_x0(raddr[i*AW +: AW])) begin
        rdata[i*XLEN +: XLEN] = '0;
        rbusy[i]              = 1'b0;
      end
    end
  end

endmodule
